// File: rtl/reset_sequencer_if.sv
// Request/control inputs and sequenced reset outputs of reset_sequencer.
// The sequencer takes the slave side; the SoC top level or a bench takes the master side.
interface reset_sequencer_if #(
  parameter int NSRC = 3,
  parameter int NOUT = 3
);
  logic [NSRC-1:0] src_req_i;
  logic            cause_clr_i;
  logic [NOUT-1:0] rst_out_n_o;
  logic            all_released_o;
  logic [NSRC-1:0] cause_o;
  logic [1:0]      state_o;

  modport master (
    output src_req_i, cause_clr_i,
    input  rst_out_n_o, all_released_o, cause_o, state_o
  );

  modport slave (
    input  src_req_i, cause_clr_i,
    output rst_out_n_o, all_released_o, cause_o, state_o
  );
endinterface

// File: rtl/reset_sequencer.sv
// Merges asynchronous reset requests, optionally debounces them, holds reset for a
// minimum time and then releases the active-low reset domains one after another.
module reset_sequencer #(
  parameter int              NSRC        = 3,
  parameter int              NOUT        = 3,
  parameter int              SYNC_STAGES = 2,
  parameter logic [NSRC-1:0] DEB_MASK    = 3'b001,
  parameter int              DEB_CYCLES  = 1024,
  parameter int              MIN_HOLD    = 16,
  parameter int              STAGE_GAP   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  reset_sequencer_if.slave io
);
  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam int HW = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
  localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [NSRC-1:0] sync_q [SYNC_STAGES];
  logic [NSRC-1:0] sync_d [SYNC_STAGES];
  logic [DW-1:0]   deb_cnt_q [NSRC];
  logic [DW-1:0]   deb_cnt_d [NSRC];
  logic [NSRC-1:0] filt_q, filt_d;
  logic [NSRC-1:0] f_prev_q, f_prev_d;
  logic [NSRC-1:0] cause_q, cause_d;
  logic [NSRC-1:0] f_s;
  logic            req_any_s;
  state_e          state_q, state_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [NOUT-1:0] out_q, out_d, out_shift_s;
  logic            all_q, all_d;

  // Synchroniser shift, per-source debounce filter and sticky cause capture.
  always_comb begin
    sync_d[0] = io.src_req_i;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    for (int i = 0; i < NSRC; i++) begin
      deb_cnt_d[i] = {DW{1'b0}};
      filt_d[i]    = 1'b0;
      f_s[i]       = sync_q[SYNC_STAGES-1][i];
      if (DEB_MASK[i]) begin
        f_s[i]    = filt_q[i];
        filt_d[i] = filt_q[i];
        if (sync_q[SYNC_STAGES-1][i] == filt_q[i]) begin
          deb_cnt_d[i] = {DW{1'b0}};
        end else if (deb_cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
          filt_d[i]    = sync_q[SYNC_STAGES-1][i];
          deb_cnt_d[i] = {DW{1'b0}};
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
        end
      end else begin
        filt_d[i] = 1'b0;
      end
    end
    req_any_s = |f_s;
    f_prev_d  = f_s;
    // A new request edge outranks a clear arriving on the same edge.
    if (io.cause_clr_i) begin
      cause_d = f_s & ~f_prev_q;
    end else begin
      cause_d = cause_q | (f_s & ~f_prev_q);
    end
  end

  // Sequencing FSM: next state and next values of the registered outputs.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    gap_d       = gap_q;
    out_d       = out_q;
    all_d       = all_q;
    out_shift_s = (out_q << 1) | NOUT'(1);
    case (state_q)
      ST_ASSERT: begin
        out_d  = {NOUT{1'b0}};
        all_d  = 1'b0;
        hold_d = {HW{1'b0}};
        gap_d  = {GW{1'b0}};
        if (req_any_s) begin
          state_d = ST_ASSERT;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (req_any_s) begin
          state_d = ST_ASSERT;
          out_d   = {NOUT{1'b0}};
          all_d   = 1'b0;
        end else if (hold_q == HW'(MIN_HOLD - 1)) begin
          out_d = NOUT'(1);
          gap_d = {GW{1'b0}};
          if (NOUT == 1) begin
            state_d = ST_DONE;
            all_d   = 1'b1;
          end else begin
            state_d = ST_RELEASE;
            all_d   = 1'b0;
          end
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      ST_RELEASE: begin
        if (req_any_s) begin
          state_d = ST_ASSERT;
          out_d   = {NOUT{1'b0}};
          all_d   = 1'b0;
        end else if (gap_q == GW'(STAGE_GAP - 1)) begin
          gap_d = {GW{1'b0}};
          out_d = out_shift_s;
          if (&out_shift_s) begin
            state_d = ST_DONE;
            all_d   = 1'b1;
          end else begin
            state_d = ST_RELEASE;
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      ST_DONE: begin
        if (req_any_s) begin
          state_d = ST_ASSERT;
          out_d   = {NOUT{1'b0}};
          all_d   = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_ASSERT;
        out_d   = {NOUT{1'b0}};
        all_d   = 1'b0;
      end
    endcase
  end

  // All state of the block, cleared by the synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= {NSRC{1'b0}};
      end
      for (int i = 0; i < NSRC; i++) begin
        deb_cnt_q[i] <= {DW{1'b0}};
      end
      filt_q   <= {NSRC{1'b0}};
      f_prev_q <= {NSRC{1'b0}};
      cause_q  <= {NSRC{1'b0}};
      state_q  <= ST_ASSERT;
      hold_q   <= {HW{1'b0}};
      gap_q    <= {GW{1'b0}};
      out_q    <= {NOUT{1'b0}};
      all_q    <= 1'b0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      for (int i = 0; i < NSRC; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
      end
      filt_q   <= filt_d;
      f_prev_q <= f_prev_d;
      cause_q  <= cause_d;
      state_q  <= state_d;
      hold_q   <= hold_d;
      gap_q    <= gap_d;
      out_q    <= out_d;
      all_q    <= all_d;
    end
  end

  assign io.rst_out_n_o    = out_q;
  assign io.all_released_o = all_q;
  assign io.cause_o        = cause_q;
  assign io.state_o        = state_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: vector table, directed corner sequences and a randomized
// phase, all also compared every cycle against a quiet-time reference model.
module tb_reset_sequencer;
  localparam int              NSRC = 3;
  localparam int              NOUT = 3;
  localparam int              SYNC = 2;
  localparam int              DEB  = 1024;
  localparam int              MINH = 16;
  localparam int              GAP  = 8;
  localparam logic [NSRC-1:0] DMASK = 3'b001;
  localparam int              REL0 = MINH + 1;
  localparam int              LAST = REL0 + (NOUT - 1) * GAP;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reset_sequencer_if #(.NSRC(NSRC), .NOUT(NOUT)) bus ();

  reset_sequencer #(
    .NSRC(NSRC), .NOUT(NOUT), .SYNC_STAGES(SYNC), .DEB_MASK(DMASK),
    .DEB_CYCLES(DEB), .MIN_HOLD(MINH), .STAGE_GAP(GAP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .io(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: reset output state follows from the count of consecutive
  // quiet edges (no filtered request), synchroniser modelled as a delay queue.
  logic [NSRC-1:0] hist [$];
  logic [NSRC-1:0] fm     = 3'b000;
  logic [NSRC-1:0] fprev  = 3'b000;
  logic [NSRC-1:0] mcause = 3'b000;
  int              run [NSRC];
  int              q = 0;

  typedef struct {
    logic            rst_n;
    logic [NSRC-1:0] src;
    logic            clr;
    int              cycles;
    logic [NOUT-1:0] out;
    logic            all;
    logic [1:0]      st;
    logic [NSRC-1:0] cause;
    string           name;
  } vec_t;

  vec_t vecs [$];

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endfunction

  task automatic model_step();
    logic [NSRC-1:0] sb;
    logic [NSRC-1:0] fb;
    if (!rst_n) begin
      hist.delete();
      for (int i = 0; i < SYNC; i++) hist.push_back(3'b000);
      fm = 3'b000; fprev = 3'b000; mcause = 3'b000; q = 0;
      for (int i = 0; i < NSRC; i++) run[i] = 0;
    end else begin
      sb = hist[0];
      for (int i = 0; i < NSRC; i++) fb[i] = DMASK[i] ? fm[i] : sb[i];
      mcause = (bus.cause_clr_i ? 3'b000 : mcause) | (fb & ~fprev);
      fprev  = fb;
      if (|fb) q = 0;
      else if (q < 1000000) q++;
      for (int i = 0; i < NSRC; i++) begin
        if (DMASK[i] && sb[i] != fm[i]) begin
          run[i]++;
          if (run[i] == DEB) begin
            fm[i]  = sb[i];
            run[i] = 0;
          end
        end else begin
          run[i] = 0;
        end
      end
      void'(hist.pop_front());
      hist.push_back(bus.src_req_i);
    end
  endtask

  task automatic check_model();
    logic [NOUT-1:0] eo;
    logic            ea;
    logic [1:0]      es;
    for (int k = 0; k < NOUT; k++) eo[k] = (q >= REL0 + k * GAP);
    ea = (q >= LAST);
    if (q == 0)         es = 2'd0;
    else if (q < REL0)  es = 2'd1;
    else if (q < LAST)  es = 2'd2;
    else                es = 2'd3;
    check("model", {23'd0, bus.rst_out_n_o, bus.all_released_o, bus.state_o, bus.cause_o},
                   {23'd0, eo, ea, es, mcause});
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic wait_state(input logic [1:0] st, input int limit, input string name);
    int k = 0;
    while (bus.state_o !== st && k < limit) begin
      tick();
      k++;
    end
    check(name, 32'(bus.state_o), 32'(st));
  endtask

  task automatic wait_out(input logic [NOUT-1:0] v, input int limit, input string name);
    int k = 0;
    while (bus.rst_out_n_o !== v && k < limit) begin
      tick();
      k++;
    end
    check(name, 32'(bus.rst_out_n_o), 32'(v));
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int n;
    bus.src_req_i   = 3'b000;
    bus.cause_clr_i = 1'b0;

    // Power-up timing, async request, re-release and cause clear.
    vecs.push_back('{1'b0, 3'b000, 1'b0,  5, 3'b000, 1'b0, 2'd0, 3'b000, "reset"});
    vecs.push_back('{1'b1, 3'b000, 1'b0, 16, 3'b000, 1'b0, 2'd1, 3'b000, "hold_e16"});
    vecs.push_back('{1'b1, 3'b000, 1'b0,  1, 3'b001, 1'b0, 2'd2, 3'b000, "bit0_e17"});
    vecs.push_back('{1'b1, 3'b000, 1'b0,  7, 3'b001, 1'b0, 2'd2, 3'b000, "gap_e24"});
    vecs.push_back('{1'b1, 3'b000, 1'b0,  1, 3'b011, 1'b0, 2'd2, 3'b000, "bit1_e25"});
    vecs.push_back('{1'b1, 3'b000, 1'b0,  7, 3'b011, 1'b0, 2'd2, 3'b000, "gap_e32"});
    vecs.push_back('{1'b1, 3'b000, 1'b0,  1, 3'b111, 1'b1, 2'd3, 3'b000, "bit2_e33"});
    vecs.push_back('{1'b1, 3'b010, 1'b0,  2, 3'b111, 1'b1, 2'd3, 3'b000, "req_e2"});
    vecs.push_back('{1'b1, 3'b010, 1'b0,  1, 3'b000, 1'b0, 2'd0, 3'b010, "req_e3"});
    vecs.push_back('{1'b1, 3'b000, 1'b0,  2, 3'b000, 1'b0, 2'd0, 3'b010, "sync_drain"});
    vecs.push_back('{1'b1, 3'b000, 1'b0,  1, 3'b000, 1'b0, 2'd1, 3'b010, "rehold"});
    vecs.push_back('{1'b1, 3'b000, 1'b0, 16, 3'b001, 1'b0, 2'd2, 3'b010, "rebit0"});
    vecs.push_back('{1'b1, 3'b000, 1'b0, 16, 3'b111, 1'b1, 2'd3, 3'b010, "redone"});
    vecs.push_back('{1'b1, 3'b000, 1'b1,  1, 3'b111, 1'b1, 2'd3, 3'b000, "clr"});

    for (int v = 0; v < vecs.size(); v++) begin
      rst_n           = vecs[v].rst_n;
      bus.src_req_i   = vecs[v].src;
      bus.cause_clr_i = vecs[v].clr;
      repeat (vecs[v].cycles) tick();
      check({vecs[v].name, "_out"},   32'(bus.rst_out_n_o),    32'(vecs[v].out));
      check({vecs[v].name, "_all"},   32'(bus.all_released_o), 32'(vecs[v].all));
      check({vecs[v].name, "_state"}, 32'(bus.state_o),        32'(vecs[v].st));
      check({vecs[v].name, "_cause"}, 32'(bus.cause_o),        32'(vecs[v].cause));
    end
    bus.cause_clr_i = 1'b0;
    bus.src_req_i   = 3'b000;

    // Bouncing key never passes the debouncer; a steady press does.
    bad = 0;
    for (int seg = 0; seg < 20; seg++) begin
      bus.src_req_i = (seg % 2 == 0) ? 3'b001 : 3'b000;
      repeat (100) begin
        tick();
        if (bus.rst_out_n_o !== 3'b111) bad++;
      end
    end
    check("t3_bounce_no_reset", 32'(bad), 32'd0);
    bus.src_req_i = 3'b001;
    n = 0;
    for (int t = 1; t <= 1100; t++) begin
      tick();
      if (n == 0 && bus.rst_out_n_o === 3'b000) n = t;
    end
    check("t3_assert_latency", 32'(n), 32'(SYNC + DEB + 1));
    check("t3_cause", 32'(bus.cause_o), 32'(3'b001));
    bus.src_req_i = 3'b000;
    wait_state(2'd3, 1500, "t3_recover");

    // Reassert between release of bit0 and bit1.
    bus.src_req_i = 3'b010;
    repeat (3) tick();
    bus.src_req_i = 3'b000;
    wait_out(3'b001, 200, "t4_bit0_released");
    bus.src_req_i = 3'b100;
    repeat (4) tick();
    bus.src_req_i = 3'b000;
    check("t4_bit0_dropped", 32'(bus.rst_out_n_o), 32'(3'b000));
    check("t4_assert_state", 32'(bus.state_o), 32'd0);
    for (int k = 1; k <= 35; k++) begin
      tick();
      if (k == 3)  check("t4_hold", 32'(bus.state_o), 32'd1);
      if (k == 18) check("t4_pre_bit0", 32'(bus.rst_out_n_o), 32'(3'b000));
      if (k == 19) check("t4_bit0", 32'(bus.rst_out_n_o), 32'(3'b001));
      if (k == 34) check("t4_bit1", 32'(bus.rst_out_n_o), 32'(3'b011));
      if (k == 35) check("t4_done", 32'({bus.rst_out_n_o, bus.all_released_o, bus.state_o}),
                                    32'({3'b111, 1'b1, 2'd3}));
    end
    check("t4_cause2", 32'(bus.cause_o[2]), 32'd1);

    // One-cycle reset while releasing.
    bus.src_req_i = 3'b010;
    repeat (3) tick();
    bus.src_req_i = 3'b000;
    wait_state(2'd2, 200, "t6_in_release");
    rst_n = 1'b0;
    tick();
    check("t6_rst_outputs", 32'({bus.rst_out_n_o, bus.all_released_o, bus.state_o}), 32'd0);
    check("t6_rst_cause", 32'(bus.cause_o), 32'd0);
    rst_n = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      tick();
      if (k == 16) check("t6_hold16", 32'({bus.rst_out_n_o, bus.state_o}), 32'({3'b000, 2'd1}));
      if (k == 17) check("t6_bit0", 32'(bus.rst_out_n_o), 32'(3'b001));
      if (k == 25) check("t6_bit1", 32'(bus.rst_out_n_o), 32'(3'b011));
      if (k == 33) check("t6_done", 32'({bus.rst_out_n_o, bus.state_o}), 32'({3'b111, 2'd3}));
    end

    // Clear on the same edge a request edge is captured.
    bus.src_req_i = 3'b010;
    tick();
    tick();
    bus.cause_clr_i = 1'b1;
    tick();
    bus.cause_clr_i = 1'b0;
    bus.src_req_i   = 3'b000;
    check("t5_set_wins", 32'(bus.cause_o), 32'(3'b010));
    wait_state(2'd3, 200, "t5_recover");
    bus.cause_clr_i = 1'b1;
    tick();
    bus.cause_clr_i = 1'b0;
    check("t5_clear", 32'(bus.cause_o), 32'd0);

    // Randomized requests, clears and resets against the model.
    for (int seg = 0; seg < 300; seg++) begin
      int              dur;
      logic [NSRC-1:0] s;
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
        rst_n = 1'b1;
      end
      s   = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
      dur = $urandom_range(1, 80);
      if ($urandom_range(0, 59) == 0) begin
        s   = 3'b001;
        dur = 1100;
      end
      bus.src_req_i   = s;
      bus.cause_clr_i = ($urandom_range(0, 7) == 0);
      tick();
      bus.cause_clr_i = 1'b0;
      repeat (dur - 1) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
